// File: rtl/beehive_output_arbiter_5.sv
// Purpose : per-output wormhole arbiter; round-robin grant among five inputs
//           presenting a head flit, then locks the output mux to the winner
//           until its whole packet (head + in_len body flits) has transferred.
// Latency : head eligible in cycle N -> sel valid, head transferable in N+1;
//           one idle arbitration cycle between back-to-back packets.
// Backpr. : out_rdy=0 or an owner bubble holds all state (no timeout); only
//           the owner is ever popped, and only when out_val & out_rdy.
// Ports   : clk, reset (sync, active-high); in_val/in_head[4:0] per input;
//           in_len_0..4 body-flit counts (sampled at grant); out_rdy from
//           downstream; sel (registered mux select, 7 = idle), out_val,
//           in_pop[4:0] (one-hot consume), busy (packet owns the output).
module beehive_output_arbiter_5 #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           in_val,
  input  logic [4:0]           in_head,
  input  logic [LEN_WIDTH-1:0] in_len_0,
  input  logic [LEN_WIDTH-1:0] in_len_1,
  input  logic [LEN_WIDTH-1:0] in_len_2,
  input  logic [LEN_WIDTH-1:0] in_len_3,
  input  logic [LEN_WIDTH-1:0] in_len_4,
  input  logic                 out_rdy,
  output logic [2:0]           sel,
  output logic                 out_val,
  output logic [4:0]           in_pop,
  output logic                 busy
);

  localparam logic [2:0] SEL_NULL = 3'd7;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [2:0]           owner, owner_nxt;
  logic [2:0]           rr_ptr, rr_ptr_nxt;
  logic [2:0]           sel_nxt;
  // One bit wider than in_len so a full-length packet plus its head fits.
  logic [LEN_WIDTH:0]   remaining, remaining_nxt;

  logic [LEN_WIDTH-1:0] len_arr [5];
  logic [4:0]           eligible;
  logic                 grant_found;
  logic [2:0]           grant_idx;
  logic                 xfer;

  assign len_arr[0] = in_len_0;
  assign len_arr[1] = in_len_1;
  assign len_arr[2] = in_len_2;
  assign len_arr[3] = in_len_3;
  assign len_arr[4] = in_len_4;

  // Only head flits can open a packet; stray body flits wait forever in IDLE.
  assign eligible = in_val & in_head;

  // Round-robin scan starting at rr_ptr, wrapping modulo 5.
  always_comb begin : arb
    logic [3:0] idx;
    idx         = 4'd0;
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    for (int k = 0; k < 5; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!grant_found && eligible[idx[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[2:0];
      end
    end
  end

  assign busy    = (state == SEND);
  assign out_val = busy && in_val[owner];
  assign xfer    = out_val && out_rdy;
  assign in_pop  = xfer ? (5'b00001 << owner) : 5'b00000;

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    sel_nxt       = sel;
    remaining_nxt = remaining;
    rr_ptr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_nxt     = SEND;
          owner_nxt     = grant_idx;
          sel_nxt       = grant_idx;
          remaining_nxt = {1'b0, len_arr[grant_idx]} + (LEN_WIDTH+1)'(1);
        end
      end
      SEND: begin
        if (xfer) begin
          remaining_nxt = remaining - (LEN_WIDTH+1)'(1);
          if (remaining == (LEN_WIDTH+1)'(1)) begin
            state_nxt  = IDLE;
            sel_nxt    = SEL_NULL;
            rr_ptr_nxt = (owner == 3'd4) ? 3'd0 : owner + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 3'd0;
      sel       <= SEL_NULL;
      remaining <= '0;
      rr_ptr    <= 3'd0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      sel       <= sel_nxt;
      remaining <= remaining_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_beehive_output_arbiter_5.sv
// Purpose : self-checking bench for beehive_output_arbiter_5; per-input packet
//           sources feed the arbiter, expected pop order lives in a scoreboard.
// Timing  : inputs driven #1 after posedge, outputs sampled on negedge.
// Flow    : sources advance only when the DUT pops them.
module tb_beehive_output_arbiter_5;

  logic       clk;
  logic       reset;
  logic [4:0] in_val;
  logic [4:0] in_head;
  logic [7:0] in_len_0, in_len_1, in_len_2, in_len_3, in_len_4;
  logic       out_rdy;
  logic [2:0] sel;
  logic       out_val;
  logic [4:0] in_pop;
  logic       busy;

  beehive_output_arbiter_5 #(.LEN_WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_head (in_head),
    .in_len_0(in_len_0),
    .in_len_1(in_len_1),
    .in_len_2(in_len_2),
    .in_len_3(in_len_3),
    .in_len_4(in_len_4),
    .out_rdy (out_rdy),
    .sel     (sel),
    .out_val (out_val),
    .in_pop  (in_pop),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Source model: srem = flits left in current packet (head included).
  int slen  [5];
  int srem  [5];
  int spkts [5];
  bit stall [5];
  bit nh    [5];   // present a lone non-head valid flit

  int q[$];        // expected popping input, in order
  int npops;
  int ntests;
  int nfail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [4:0] v, h;
    v = '0;
    h = '0;
    for (int i = 0; i < 5; i++) begin
      v[i] = nh[i] || (srem[i] > 0 && !stall[i]);
      h[i] = !nh[i] && srem[i] > 0 && srem[i] == slen[i] + 1;
    end
    in_val   = v;
    in_head  = h;
    in_len_0 = 8'(slen[0]);
    in_len_1 = 8'(slen[1]);
    in_len_2 = 8'(slen[2]);
    in_len_3 = 8'(slen[3]);
    in_len_4 = 8'(slen[4]);
  endtask

  task automatic load(input int i, input int len, input int n);
    slen[i]  = len;
    srem[i]  = len + 1;
    spkts[i] = n - 1;
  endtask

  task automatic push_n(input int i, input int n);
    for (int k = 0; k < n; k++) q.push_back(i);
  endtask

  // One clock: compare pops against the scoreboard, advance sources, redrive.
  task automatic step();
    logic [4:0] p;
    logic [4:0] ex;
    int e;
    @(negedge clk);
    p = in_pop;
    if (p != 5'b0) begin
      npops++;
      if (q.size() == 0) begin
        check("pop_extra", 32'(p), 32'd0);
      end else begin
        e  = q.pop_front();
        ex = 5'b00001 << e;
        check("pop_order", 32'(p), 32'(ex));
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (p[i] === 1'b1) begin
        srem[i]--;
        if (srem[i] == 0 && spkts[i] > 0) begin
          srem[i] = slen[i] + 1;
          spkts[i]--;
        end
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_src();
    for (int i = 0; i < 5; i++) begin
      slen[i] = 0; srem[i] = 0; spkts[i] = 0; stall[i] = 0; nh[i] = 0;
    end
  endtask

  task automatic do_reset();
    clear_src();
    q.delete();
    reset = 1'b1;
    drive();
    repeat (2) step();
    reset   = 1'b0;
    out_rdy = 1'b1;
    npops   = 0;
  endtask

  int order[3] = '{0, 1, 4};

  initial begin
    ntests  = 0;
    nfail   = 0;
    npops   = 0;
    out_rdy = 1'b1;
    reset   = 1'b1;
    clear_src();
    drive();

    // Reset state
    do_reset();
    #1;
    check("rst_sel", 32'(sel), 32'd7);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_val", 32'(out_val), 32'd0);
    check("rst_in_pop", 32'(in_pop), 32'd0);
    check("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    check("rst_remaining", 32'(dut.remaining), 32'd0);

    // Single packet: input 2, three body flits
    load(2, 3, 1);
    push_n(2, 4);
    drive();
    step();
    check("single_sel", 32'(sel), 32'd2);
    check("single_busy", 32'(busy), 32'd1);
    repeat (3) step();
    check("single_busy_mid", 32'(busy), 32'd1);
    step();
    check("single_sel_rel", 32'(sel), 32'd7);
    check("single_rr_ptr", 32'(dut.rr_ptr), 32'd3);
    check("single_npops", 32'(npops), 32'd4);
    check("single_sb_empty", 32'(q.size()), 32'd0);

    // Round-robin fairness: head-only packets on 0, 1, 4
    do_reset();
    load(0, 0, 3);
    load(1, 0, 3);
    load(4, 0, 3);
    for (int k = 0; k < 9; k++) q.push_back(order[k % 3]);
    drive();
    for (int k = 0; k < 9; k++) begin
      step();
      check("rr_grant", 32'(sel), 32'(order[k % 3]));
      step();
      check("rr_gap", 32'(sel), 32'd7);
    end
    check("rr_npops", 32'(npops), 32'd9);
    check("rr_sb_empty", 32'(q.size()), 32'd0);

    // Backpressure and owner bubbles: input 3, two body flits
    do_reset();
    load(3, 2, 1);
    push_n(3, 3);
    drive();
    step();
    check("bp_sel", 32'(sel), 32'd3);
    step();
    out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_busy_rdy", 32'(busy), 32'd1);
    end
    check("bp_npops_rdy", 32'(npops), 32'd1);
    out_rdy  = 1'b1;
    stall[3] = 1'b1;
    drive();
    for (int k = 0; k < 2; k++) begin
      step();
      check("bp_busy_bubble", 32'(busy), 32'd1);
    end
    check("bp_npops_bubble", 32'(npops), 32'd1);
    stall[3] = 1'b0;
    drive();
    step();
    check("bp_busy_2nd", 32'(busy), 32'd1);
    step();
    check("bp_sel_rel", 32'(sel), 32'd7);
    check("bp_busy_rel", 32'(busy), 32'd0);
    check("bp_npops", 32'(npops), 32'd3);
    check("bp_sb_empty", 32'(q.size()), 32'd0);

    // Lock integrity: input 0 raises a head while input 1 owns the output
    do_reset();
    load(1, 2, 1);
    push_n(1, 3);
    push_n(0, 1);
    drive();
    step();
    check("lock_sel1", 32'(sel), 32'd1);
    load(0, 0, 1);
    drive();
    repeat (2) step();
    check("lock_sel_hold", 32'(sel), 32'd1);
    step();
    check("lock_sel_rel", 32'(sel), 32'd7);
    step();
    check("lock_sel0", 32'(sel), 32'd0);
    step();
    check("lock_sel_end", 32'(sel), 32'd7);
    check("lock_sb_empty", 32'(q.size()), 32'd0);

    // Maximum length: 255 body flits on input 4
    do_reset();
    load(4, 255, 1);
    push_n(4, 256);
    drive();
    step();
    check("max_sel", 32'(sel), 32'd4);
    check("max_remaining", 32'(dut.remaining), 32'd256);
    for (int k = 0; k < 256; k++) begin
      step();
      if (k == 254) check("max_busy_penult", 32'(busy), 32'd1);
    end
    check("max_npops", 32'(npops), 32'd256);
    check("max_sel_rel", 32'(sel), 32'd7);
    check("max_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    check("max_sb_empty", 32'(q.size()), 32'd0);

    // Non-head valid flit in IDLE: never granted, never popped
    do_reset();
    nh[2] = 1'b1;
    drive();
    repeat (3) step();
    check("nohead_sel", 32'(sel), 32'd7);
    check("nohead_busy", 32'(busy), 32'd0);
    check("nohead_npops", 32'(npops), 32'd0);

    // Reset mid-packet abandons the packet
    do_reset();
    load(2, 0, 1);
    push_n(2, 2);
    drive();
    repeat (3) step();   // grant 2, pop head, re-grant? no: head-only then idle
    check("mid_pre_npops", 32'(npops), 32'd1);
    q.delete();
    load(1, 5, 1);
    push_n(1, 2);
    drive();
    step();
    check("mid_sel1", 32'(sel), 32'd1);
    repeat (2) step();
    check("mid_remaining", 32'(dut.remaining), 32'd4);
    check("mid_rr_ptr_pre", 32'(dut.rr_ptr), 32'd3);
    out_rdy = 1'b0;
    reset   = 1'b1;
    step();
    check("mid_rst_sel", 32'(sel), 32'd7);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    check("mid_rst_remaining", 32'(dut.remaining), 32'd0);
    check("mid_npops", 32'(npops), 32'd3);
    reset = 1'b0;
    clear_src();
    q.delete();
    drive();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
